// File: rtl/ss_adc_scan_ctrl.sv
// ss_adc_scan_ctrl: round-robin conversion sequencer for a shared single-slope ADC ramp
module ss_adc_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_CYCLES = 2,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              comp,
  input  logic [WIDTH-1:0]  count_true,
  output logic [WIDTH-1:0]  counter,
  output logic              ramp_rst,
  output logic              ramp_en,
  output logic              sampler_rst,
  output logic [CW-1:0]     ch_sel,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic [CW-1:0]     res_ch,
  output logic              res_ovr,
  output logic              busy
);
  localparam int CNTW = $clog2((SETTLE_CYCLES > DRAIN_CYCLES ? SETTLE_CYCLES : DRAIN_CYCLES) + 1);
  localparam logic [WIDTH-1:0] MAX = '1;
  typedef enum logic [2:0] {IDLE, SETTLE, RAMP, DRAIN, OUTPUT} state_t;
  state_t state;
  logic [CNTW-1:0] cnt;
  logic phase, ovr, hit;
  logic [CW-1:0] lo_ch, nx_ch, next_ch;
  always_comb begin
    lo_ch = ch_sel;
    nx_ch = '0;
    hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) lo_ch = CW'(i);
      if (ch_mask[i] && i > int'(ch_sel)) begin
        nx_ch = CW'(i);
        hit = 1'b1;
      end
    end
  end
  assign next_ch = hit ? nx_ch : lo_ch;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      phase <= 1'b0;
      ovr <= 1'b0;
      counter <= '0;
      ramp_rst <= 1'b1;
      ramp_en <= 1'b0;
      sampler_rst <= 1'b1;
      ch_sel <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_ch <= '0;
      res_ovr <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run && |ch_mask) begin
          state <= SETTLE;
          ch_sel <= lo_ch;
          cnt <= '0;
          busy <= 1'b1;
        end
        SETTLE: begin
          phase <= 1'b0;
          counter <= '0;
          if (cnt == CNTW'(SETTLE_CYCLES - 1)) begin
            state <= RAMP;
            ramp_rst <= 1'b0;
            sampler_rst <= 1'b0;
            ramp_en <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        RAMP: begin
          phase <= ~phase;
          // comp is only trusted in phase 0; phase 1 is the sampler's reset half
          if ((!phase && comp) || (phase && counter == MAX)) begin
            state <= DRAIN;
            ovr <= phase;
            ramp_en <= 1'b0;
            cnt <= '0;
          end else if (phase) counter <= counter + 1'b1;
        end
        DRAIN: begin
          if (cnt == CNTW'(DRAIN_CYCLES - 1)) begin
            state <= OUTPUT;
            res_valid <= 1'b1;
            res_data <= ovr ? MAX : count_true;
            res_ch <= ch_sel;
            res_ovr <= ovr;
            ramp_rst <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        OUTPUT: if (res_ready) begin
          res_valid <= 1'b0;
          sampler_rst <= 1'b1;
          counter <= '0;
          cnt <= '0;
          if (run && |ch_mask) begin
            state <= SETTLE;
            ch_sel <= next_ch;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
